seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an N-digit common-anode/cathode 7-segment display.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg_slot_timer.sv | 34 +++
 rtl/seg_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
//   state_t        : scan FSM states (IDLE, SHOW, BLANK)
//   SEG_BLANK_CODE : decoder code that produces an all-off digit
//   onehot()       : digit-enable pattern for a given digit index
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [4:0] SEG_BLANK_CODE = 5'd31;

  // Widest digit-enable vector onehot() can produce; callers cast down.
  localparam int MAX_DIGITS = 32;

  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
    return {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Phase timer for the scan FSM. Counts cycles spent in the current phase and
// flags the terminal cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : phase in progress (counter advances)
//   clr        : restart counting at zero on the next edge (wins over run)
//   last       : terminal count of the current phase (phase length - 1)
//   done       : high during the final cycle of the phase
module seg_slot_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // The counter never wraps on its own; the FSM restarts it on every phase change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = run && (cnt == last);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display that
// shares one external BCD-to-7-segment decoder across all digits. The shown
// value is double-buffered so an update only takes effect at a frame boundary.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; low forces the display dark
//   load, value : capture strobe and packed BCD value (digit 0 in [3:0])
//   lz_suppress : blank leading zeros (digit 0 is always shown)
//   load_ack    : pulse when a loaded value becomes the displayed value
//   frame_done  : pulse in the last cycle of every full scan frame
//   dec_bcd     : code to the shared decoder (0-15 nibble, 31 = blank)
//   dec_seg     : decoder result, bit6=a .. bit0=g, active-high
//   seg_out, an : registered segments and one-hot digit enable
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                lz_suppress,
  output logic                load_ack,
  output logic                frame_done,
  output logic [4:0]          dec_bcd,
  input  logic [6:0]          dec_seg,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   an
);

  localparam int MAX_LEN = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int IDX_W   = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [4*DIGITS-1:0] active, pending_val;
  logic               pending;
  logic               idle_ack;

  logic               phase_done;
  logic [CNT_W-1:0]   phase_last;
  logic               timer_run, timer_clr;
  logic               last_phase;
  logic               frame_end;

  logic [DIGITS-1:0]  zero_from;
  logic               tail_zero;
  logic [3:0]         cur_nib;
  logic               cur_zero;

  // Phase timing
  assign phase_last = (state == BLANK) ? BLANK_LAST : SHOW_LAST;
  assign timer_run  = en && (state != IDLE);
  assign timer_clr  = !en || (state == IDLE) || phase_done;

  seg_slot_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (timer_run),
    .clr   (timer_clr),
    .last  (phase_last),
    .done  (phase_done)
  );

  // Without a blank phase the frame closes at the end of the last digit's SHOW.
  assign last_phase = (BLANK_CYC == 0) ? (state == SHOW) : (state == BLANK);
  assign frame_end  = phase_done && last_phase && (idx == IDX_LAST);
  assign frame_done = frame_end;

  // Scan FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    if (!en) begin
      state_next = IDLE;
      idx_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_next = SHOW;
          idx_next   = '0;
        end
        SHOW: begin
          if (phase_done) begin
            if (BLANK_CYC == 0) begin
              idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              state_next = BLANK;
            end
          end
        end
        BLANK: begin
          if (phase_done) begin
            state_next = SHOW;
            idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
        end
      endcase
    end
  end

  // Shadow / active value buffers
  // A load in the boundary cycle bypasses the shadow so it is not lost behind
  // an older pending value; while idle there is no frame to protect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= '0;
      pending_val <= '0;
      pending     <= 1'b0;
      idle_ack    <= 1'b0;
    end else begin
      idle_ack <= 1'b0;
      if ((state == IDLE) && load) begin
        active   <= value;
        pending  <= 1'b0;
        idle_ack <= 1'b1;
      end else if (frame_end && load) begin
        active  <= value;
        pending <= 1'b0;
      end else if (frame_end && pending) begin
        active  <= pending_val;
        pending <= 1'b0;
      end else if (load) begin
        pending_val <= value;
        pending     <= 1'b1;
      end
    end
  end

  assign load_ack = idle_ack || (frame_end && (load || pending));

  // Decoder request
  // zero_from[i] is set when digits i..DIGITS-1 are all zero.
  always_comb begin
    zero_from = '0;
    tail_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      tail_zero    = tail_zero && (active[4*i +: 4] == 4'd0);
      zero_from[i] = tail_zero;
    end
  end

  always_comb begin
    cur_nib  = 4'd0;
    cur_zero = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib  = active[4*i +: 4];
        cur_zero = zero_from[i];
      end
    end
  end

  always_comb begin
    dec_bcd = SEG_BLANK_CODE;
    if (state == SHOW) begin
      if (lz_suppress && (idx != '0) && cur_zero) begin
        dec_bcd = SEG_BLANK_CODE;
      end else begin
        dec_bcd = {1'b0, cur_nib};
      end
    end
  end

  // Output register stage: segments and enable leave on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
      an      <= '0;
    end else if (state == SHOW) begin
      seg_out <= dec_seg;
      an      <= DIGITS'(onehot(int'(idx)));
    end else begin
      seg_out <= '0;
      an      <= '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int R = 4;
  localparam int B = 2;

  localparam int M_IDLE  = 0;
  localparam int M_SHOW  = 1;
  localparam int M_BLANK = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic          lz_suppress = 1'b0;
  logic          load_ack, frame_done;
  logic [4:0]    dec_bcd;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_out;
  logic [D-1:0]  an;

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [4:0] c);
    case (c)
      5'd0: return 7'b1111110;
      5'd1: return 7'b0110000;
      5'd2: return 7'b1101101;
      5'd3: return 7'b1111001;
      5'd4: return 7'b0110011;
      5'd5: return 7'b1011011;
      5'd6: return 7'b1011111;
      5'd7: return 7'b1110000;
      5'd8: return 7'b1111111;
      5'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  assign dec_seg = dec7(dec_bcd);

  seg_scan_ctrl #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .lz_suppress(lz_suppress), .load_ack(load_ack), .frame_done(frame_done),
    .dec_bcd(dec_bcd), .dec_seg(dec_seg), .seg_out(seg_out), .an(an)
  );

  typedef struct packed {
    logic [D-1:0] an;
    logic [6:0]   seg;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int          m_st, m_idx, m_cnt;
  logic [15:0] m_active, m_pval;
  bit          m_pend, m_ackq;

  logic         o_fd, o_ack;
  logic [D-1:0] o_an;
  logic [6:0]   o_seg;

  task automatic model_reset();
    m_st = M_IDLE; m_idx = 0; m_cnt = 0;
    m_active = '0; m_pval = '0; m_pend = 0; m_ackq = 0;
    q.delete();
  endtask

  function automatic bit m_boundary(input bit e);
    if (!e || m_idx != D - 1) return 0;
    if (B == 0) return (m_st == M_SHOW) && (m_cnt == R - 1);
    return (m_st == M_BLANK) && (m_cnt == B - 1);
  endfunction

  function automatic logic [4:0] m_dec();
    logic [3:0] nib;
    bit zero;
    if (m_st != M_SHOW) return 5'd31;
    nib  = m_active[m_idx*4 +: 4];
    zero = 1;
    for (int k = m_idx; k < D; k++) if (m_active[k*4 +: 4] != 0) zero = 0;
    if (lz_suppress && m_idx > 0 && zero) return 5'd31;
    return {1'b0, nib};
  endfunction

  // One clock of stimulus: compares combinational outputs before the edge and
  // the registered outputs queued for after the edge.
  task automatic step(input bit e, input bit ld, input logic [15:0] v);
    exp_t x;
    bit b, exp_ack;
    logic [4:0] exp_dec;
    en = e; load = ld; value = v;
    #1;
    b       = m_boundary(e);
    exp_dec = m_dec();
    exp_ack = m_ackq || (b && (ld || m_pend));
    o_fd = frame_done; o_ack = load_ack;
    n_checks++;
    if (frame_done !== b) $display("FAIL frame_done cyc=%0d got=%b want=%b", cyc, frame_done, b);
    else n_pass++;
    n_checks++;
    if (load_ack !== exp_ack) $display("FAIL load_ack cyc=%0d got=%b want=%b", cyc, load_ack, exp_ack);
    else n_pass++;
    n_checks++;
    if (dec_bcd !== exp_dec) $display("FAIL dec_bcd cyc=%0d got=%0d want=%0d", cyc, dec_bcd, exp_dec);
    else n_pass++;
    x.an  = (m_st == M_SHOW) ? D'(1 << m_idx) : '0;
    x.seg = (m_st == M_SHOW) ? dec7(exp_dec) : 7'd0;
    q.push_back(x);
    m_ackq = 0;
    if (m_st == M_IDLE && ld) begin m_active = v; m_pend = 0; m_ackq = 1; end
    else if (b && ld) begin m_active = v; m_pend = 0; end
    else if (b && m_pend) begin m_active = m_pval; m_pend = 0; end
    else if (ld) begin m_pval = v; m_pend = 1; end
    if (!e) begin
      m_st = M_IDLE; m_idx = 0; m_cnt = 0;
    end else if (m_st == M_IDLE) begin
      m_st = M_SHOW; m_idx = 0; m_cnt = 0;
    end else if (m_st == M_SHOW) begin
      if (m_cnt == R - 1) begin
        m_cnt = 0;
        if (B == 0) m_idx = (m_idx + 1) % D;
        else m_st = M_BLANK;
      end else m_cnt++;
    end else begin
      if (m_cnt == B - 1) begin
        m_cnt = 0; m_st = M_SHOW; m_idx = (m_idx + 1) % D;
      end else m_cnt++;
    end
    @(posedge clk); #1;
    cyc++;
    o_an = an; o_seg = seg_out;
    n_checks++;
    if (q.size() == 0) begin
      $display("FAIL scoreboard_empty cyc=%0d", cyc);
    end else begin
      x = q.pop_front();
      if (an !== x.an || seg_out !== x.seg)
        $display("FAIL an_seg cyc=%0d got an=%b seg=%b want an=%b seg=%b", cyc, an, seg_out, x.an, x.seg);
      else n_pass++;
    end
    @(negedge clk);
  endtask

  task automatic expect_seen(input string name, input bit seen);
    n_checks++;
    if (!seen) $display("FAIL %s got=not_observed want=observed", name);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    #1;
    n_checks++;
    if (an !== '0 || seg_out !== '0) $display("FAIL reset_out got an=%b seg=%b want 0", an, seg_out);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0 || load_ack !== 1'b0) $display("FAIL reset_pulse got fd=%b ack=%b want 0", frame_done, load_ack);
    else n_pass++;
    n_checks++;
    if (dec_bcd !== 5'd31) $display("FAIL reset_dec got=%0d want=31", dec_bcd);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    int fd_first = -1, fd_period = -1;
    bit seen4 = 0;
    lz_suppress = 0;
    step(1, 1, 16'h1234);
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 16'h0);
      if (o_fd) begin
        if (fd_first < 0) fd_first = cyc;
        else if (fd_period < 0) fd_period = cyc - fd_first;
      end
      if (o_an == 4'b0001 && !seen4) begin
        seen4 = 1;
        n_checks++;
        if (o_seg !== 7'b0110011) $display("FAIL digit0_is_4 got=%b want=%b", o_seg, 7'b0110011);
        else n_pass++;
      end
    end
    expect_seen("digit0_lit", seen4);
    n_checks++;
    if (fd_period !== 24) $display("FAIL frame_period got=%0d want=24", fd_period);
    else n_pass++;
  endtask

  task automatic test_lz();
    bit acked = 0, s0 = 0, s1 = 0, s2 = 0;
    lz_suppress = 1;
    step(1, 1, 16'h0070);
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 16'h0);
      if (o_ack) acked = 1;
      else if (acked) begin
        if (o_an == 4'b0001 && !s0) begin
          s0 = 1; n_checks++;
          if (o_seg !== 7'b1111110) $display("FAIL lz_digit0 got=%b want=%b", o_seg, 7'b1111110); else n_pass++;
        end
        if (o_an == 4'b0010 && !s1) begin
          s1 = 1; n_checks++;
          if (o_seg !== 7'b1110000) $display("FAIL lz_digit1 got=%b want=%b", o_seg, 7'b1110000); else n_pass++;
        end
        if (o_an == 4'b1000 && !s2) begin
          s2 = 1; n_checks++;
          if (o_seg !== 7'b0000000) $display("FAIL lz_digit3 got=%b want=0", o_seg); else n_pass++;
        end
      end
    end
    expect_seen("lz_0070_digits", s0 && s1 && s2);
    acked = 0; s0 = 0; s1 = 0;
    step(1, 1, 16'h0000);
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 16'h0);
      if (o_ack) acked = 1;
      else if (acked) begin
        if (o_an == 4'b0001 && !s0) begin
          s0 = 1; n_checks++;
          if (o_seg !== 7'b1111110) $display("FAIL lz_zero_d0 got=%b want=%b", o_seg, 7'b1111110); else n_pass++;
        end
        if (o_an == 4'b0010 && !s1) begin
          s1 = 1; n_checks++;
          if (o_seg !== 7'b0000000) $display("FAIL lz_zero_d1 got=%b want=0", o_seg); else n_pass++;
        end
      end
    end
    expect_seen("lz_zero_digits", s0 && s1);
    lz_suppress = 0;
  endtask

  task automatic test_double_load();
    int acks = 0;
    bit found = 0, s9 = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_st == M_SHOW && m_idx == 1) found = 1;
      else step(1, 0, 16'h0);
    end
    expect_seen("reach_digit1", found);
    step(1, 1, 16'h5678);
    if (o_ack) acks++;
    step(1, 0, 16'h0);
    if (o_ack) acks++;
    step(1, 1, 16'h9999);
    if (o_ack) acks++;
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 16'h0);
      if (o_ack) acks++;
      if (acks > 0 && o_an == 4'b0001 && !s9) begin
        s9 = 1; n_checks++;
        if (o_seg !== 7'b1111011) $display("FAIL last_load_wins got=%b want=%b", o_seg, 7'b1111011); else n_pass++;
      end
    end
    expect_seen("new_value_shown", s9);
    n_checks++;
    if (acks !== 1) $display("FAIL ack_count got=%0d want=1", acks);
    else n_pass++;
  endtask

  task automatic test_load_at_boundary();
    bit hit = 0, s1 = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (m_boundary(1)) begin
        hit = 1;
        step(1, 1, 16'h4321);
        n_checks++;
        if (o_fd !== 1'b1 || o_ack !== 1'b1) $display("FAIL boundary_load got fd=%b ack=%b want 1 1", o_fd, o_ack);
        else n_pass++;
      end else step(1, 0, 16'h0);
    end
    expect_seen("boundary_reached", hit);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 16'h0);
      if (o_an == 4'b0001 && !s1) begin
        s1 = 1; n_checks++;
        if (o_seg !== 7'b0110000) $display("FAIL boundary_digit0 got=%b want=%b", o_seg, 7'b0110000); else n_pass++;
      end
    end
    expect_seen("boundary_digit0_lit", s1);
  endtask

  task automatic test_en_drop();
    bit found = 0;
    int lit = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_st == M_SHOW && m_cnt == 1) found = 1;
      else step(1, 0, 16'h0);
    end
    expect_seen("reach_mid_show", found);
    step(0, 0, 16'h0);
    step(0, 0, 16'h0);
    n_checks++;
    if (o_an !== '0 || o_seg !== '0) $display("FAIL en_drop_dark got an=%b seg=%b want 0", o_an, o_seg);
    else n_pass++;
    step(0, 0, 16'h0);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 16'h0);
      if (o_an == 4'b0001) lit++;
    end
    n_checks++;
    if (lit !== 4) $display("FAIL restart_digit0_len got=%0d want=4", lit);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit found = 0, s0 = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_st == M_BLANK) found = 1;
      else step(1, 0, 16'h0);
    end
    expect_seen("reach_blank", found);
    step(1, 0, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (an !== '0 || seg_out !== '0 || frame_done !== 1'b0 || load_ack !== 1'b0)
      $display("FAIL async_reset got an=%b seg=%b fd=%b ack=%b want 0", an, seg_out, frame_done, load_ack);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 16'h0);
      if (o_an != '0 && !s0) begin
        s0 = 1; n_checks++;
        if (o_an !== 4'b0001 || o_seg !== 7'b1111110)
          $display("FAIL reset_restart got an=%b seg=%b want an=0001 seg=1111110", o_an, o_seg);
        else n_pass++;
      end
    end
    expect_seen("reset_restart_lit", s0);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_double_load();
    test_load_at_boundary();
    test_en_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
